// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RV32I control FSM with fetch/data memory wait timeout.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap unrecognised opcodes instead of executing them as NOPs.
module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [2:0]  imm_fmt,
    output logic        alu_src_imm,
    input  logic        branch_taken,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        retire,
    output logic        bus_err,
    output logic        illegal
);
    localparam int CW = $clog2(MEM_WAIT_MAX + 1);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR, S_TRAP} state_t;
`else
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR} state_t;
`endif
    state_t        r_state, w_next;
    logic [31:0]   r_ir;
    logic [2:0]    r_imm_fmt, w_fmt;
    logic [CW-1:0] r_wait;
    logic [6:0]    w_op;
    logic          w_load, w_store, w_branch, w_jal, w_jalr, w_alu, w_timeout, w_imm_alu;

    assign w_op      = r_ir[6:0];
    assign w_load    = w_op == 7'b0000011;
    assign w_store   = w_op == 7'b0100011;
    assign w_branch  = w_op == 7'b1100011;
    assign w_jal     = w_op == 7'b1101111;
    assign w_jalr    = w_op == 7'b1100111;
    assign w_alu     = w_op == 7'b0010011 || w_op == 7'b0110011 || w_op == 7'b0110111 || w_op == 7'b0010111;
    assign w_timeout = r_wait == CW'(MEM_WAIT_MAX);
    assign w_imm_alu = r_imm_fmt != 3'd0 && !w_branch;
    assign w_fmt     = (w_op == 7'b0010011 || w_load || w_jalr) ? 3'd1 :
                       w_store ? 3'd2 :
                       w_branch ? 3'd3 :
                       w_jal ? 3'd4 :
                       (w_op == 7'b0110111 || w_op == 7'b0010111) ? 3'd5 : 3'd0;
    assign ir        = r_ir;
    assign imm_fmt   = r_imm_fmt;
    assign bus_err   = r_state == S_ERR;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    assign illegal   = r_state == S_TRAP;
`else
    assign illegal   = 1'b0;
`endif

    always_comb begin
        w_next      = r_state;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 2'd0;
        pc_we       = 1'b0;
        pc_sel      = 2'd0;
        retire      = 1'b0;
        alu_src_imm = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                w_next   = imem_ready ? S_DECODE : w_timeout ? S_ERR : S_FETCH;
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                alu_src_imm = w_imm_alu;
                if (w_load || w_store)
                    w_next = S_MEM;
                else if (w_branch) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? 2'd1 : 2'd0;
                    retire = 1'b1;
                    w_next = S_FETCH;
                end else if (w_alu || w_jal || w_jalr)
                    w_next = S_WB;
                else begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                    w_next = S_TRAP;
`else
                    pc_we  = 1'b1;
                    retire = 1'b1;
                    w_next = S_FETCH;
`endif
                end
            end
            S_MEM: begin
                alu_src_imm = w_imm_alu;
                dmem_req    = 1'b1;
                dmem_we     = w_store;
                pc_we       = dmem_ready && w_store;
                retire      = dmem_ready && w_store;
                w_next      = dmem_ready ? (w_store ? S_FETCH : S_WB) : w_timeout ? S_ERR : S_MEM;
            end
            S_WB: begin
                alu_src_imm = w_imm_alu;
                reg_we      = 1'b1;
                pc_we       = 1'b1;
                retire      = 1'b1;
                wb_sel      = w_load ? 2'd1 : (w_jal || w_jalr) ? 2'd2 : 2'd0;
                pc_sel      = w_jal ? 2'd2 : w_jalr ? 2'd3 : 2'd0;
                w_next      = S_FETCH;
            end
            default: ;
        endcase
    end

    // The wait counter restarts whenever a new state is entered and only counts while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_ir      <= 32'h00000013;
            r_imm_fmt <= 3'd0;
            r_wait    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && imem_ready)
                r_ir <= imem_rdata;
            if (r_state == S_DECODE)
                r_imm_fmt <= w_fmt;
            r_wait <= (w_next != r_state) ? '0 :
                      (r_state == S_FETCH || r_state == S_MEM) ? r_wait + 1'b1 : r_wait;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction stream checked cycle by cycle against an
// instruction-level model of the controller, plus directed timeout, trap and reset cases.
module tb_multicycle_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_ready = 1'b0, branch_taken = 1'b0, dmem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0, ir;
    logic        imem_req, alu_src_imm, dmem_req, dmem_we, reg_we, pc_we, retire, bus_err, illegal;
    logic [2:0]  imm_fmt, cur_fmt;
    logic [1:0]  wb_sel, pc_sel;
    logic [15:0] obs;
    logic [6:0]  ops [10];
    int          total = 0, bad = 0, cyc_cnt = 0, ret_at = 0;

    multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .ir(ir), .imm_fmt(imm_fmt), .alu_src_imm(alu_src_imm), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready), .reg_we(reg_we),
        .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .retire(retire), .bus_err(bus_err),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign obs = {imem_req, dmem_req, dmem_we, reg_we, wb_sel, pc_we, pc_sel, retire,
                  alu_src_imm, bus_err, illegal, imm_fmt};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] rw();
        return $urandom();
    endfunction

    function automatic logic [15:0] pk(input logic [2:0] f, input logic ireq, dreq, dwe, rwe,
                                       input logic [1:0] ws, input logic pwe, input logic [1:0] ps,
                                       input logic rt, as, be, il);
        return {ireq, dreq, dwe, rwe, ws, pwe, ps, rt, as, be, il, f};
    endfunction

    // One clock cycle: drive inputs after the falling edge, compare outputs 1 time unit later.
    task automatic step(input logic ir_rdy, input logic [31:0] rdata, input logic dr_rdy,
                        input logic bt, input logic [15:0] exp, input string tag);
        @(negedge clk);
        rst = 1'b0;
        imem_ready = ir_rdy;
        imem_rdata = rdata;
        dmem_ready = dr_rdy;
        branch_taken = bt;
        #1;
        cyc_cnt++;
        if (retire && ret_at == 0)
            ret_at = cyc_cnt;
        check(tag, {16'd0, obs}, {16'd0, exp});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rst_state", {16'd0, obs}, {16'd0, pk(3'd0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0)});
        check("rst_ir", ir, 32'h00000013);
        cur_fmt = 3'd0;
    endtask

    // Instruction-level model: expected cycle sequence derived from the opcode class and wait counts.
    task automatic run(input logic [31:0] ins, input int fw, input int dw, input logic bt);
        logic [6:0] op;
        logic [2:0] nf;
        logic       ld, st, br, jl, jr, ok, as, last;
        int         base;
        op = ins[6:0];
        ld = op == 7'h03;
        st = op == 7'h23;
        br = op == 7'h63;
        jl = op == 7'h6f;
        jr = op == 7'h67;
        ok = ld | st | br | jl | jr | op == 7'h13 | op == 7'h33 | op == 7'h37 | op == 7'h17;
        case (op)
            7'h13, 7'h03, 7'h67: nf = 3'd1;
            7'h23:               nf = 3'd2;
            7'h63:               nf = 3'd3;
            7'h6f:               nf = 3'd4;
            7'h37, 7'h17:        nf = 3'd5;
            default:             nf = 3'd0;
        endcase
        as = nf != 3'd0 && !br;
        cyc_cnt = 0;
        ret_at = 0;
        for (int i = 0; i <= fw; i++)
            step(i == fw, ins, rb(), rb(), pk(cur_fmt, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0), "fetch");
        step(rb(), rw(), rb(), rb(), pk(cur_fmt, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0), "decode");
        check("ir", ir, ins);
        cur_fmt = nf;
        if (br)
            step(rb(), rw(), rb(), bt, pk(nf, 0, 0, 0, 0, 2'd0, 1, {1'b0, bt}, 1, 0, 0, 0), "exec_branch");
        else if (!ok)
            step(rb(), rw(), rb(), rb(), pk(nf, 0, 0, 0, 0, 2'd0, 1, 2'd0, 1, 0, 0, 0), "exec_nop");
        else
            step(rb(), rw(), rb(), rb(), pk(nf, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, as, 0, 0), "exec");
        if (ld | st)
            for (int i = 0; i <= dw; i++) begin
                last = i == dw;
                step(rb(), rw(), last, rb(),
                     pk(nf, 0, 1, st, 0, 2'd0, st & last, 2'd0, st & last, as, 0, 0), "mem");
            end
        if (ok && !br && !st)
            step(rb(), rw(), rb(), rb(),
                 pk(nf, 0, 0, 0, 1, ld ? 2'd1 : (jl | jr) ? 2'd2 : 2'd0, 1,
                    jl ? 2'd2 : jr ? 2'd3 : 2'd0, 1, as, 0, 0), "wb");
        base = (br || !ok) ? 3 : ld ? 5 : 4;
        check("latency", ret_at, base + fw + ((ld | st) ? dw : 0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          n;
        ops = '{7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h13, 7'h33, 7'h37, 7'h17, 7'h7f};
        cur_fmt = 3'd0;
        do_reset();
        run(32'h00500093, 0, 0, 1'b0);
        run(32'h0000A103, 0, 3, 1'b0);
        run(32'h00000463, 0, 0, 1'b1);
        run(32'h00000463, 1, 0, 1'b0);
        run(32'h0020A023, 2, 1, 1'b0);
        run(32'h008000EF, 0, 0, 1'b0);
        run(32'h000080E7, 1, 0, 1'b0);
        run(32'h123450B7, 0, 0, 1'b0);
        run(32'h00001097, 0, 0, 1'b0);
        run(32'h002081B3, 0, 0, 1'b0);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        n = 8;
`else
        n = 9;
`endif
        for (int k = 0; k < 200; k++) begin
            r = rw();
            run({r[31:7], ops[$urandom_range(0, n)]}, $urandom_range(0, 3), $urandom_range(0, 3), rb());
        end
        run(32'h00500093, 15, 0, 1'b0);
        for (int i = 0; i < 16; i++)
            step(1'b0, rw(), rb(), rb(), pk(cur_fmt, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0), "fetch_wait");
        for (int i = 0; i < 3; i++)
            step(1'b1, rw(), 1'b1, rb(), pk(cur_fmt, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 1, 0), "err_hold");
        do_reset();
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        step(1'b1, 32'h0000007F, 1'b0, 1'b0, pk(3'd0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0), "fetch_ill");
        step(1'b0, rw(), 1'b0, 1'b0, pk(3'd0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0), "decode_ill");
        step(1'b0, rw(), 1'b0, 1'b0, pk(3'd0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0), "exec_ill");
        for (int i = 0; i < 3; i++)
            step(1'b1, rw(), 1'b1, rb(), pk(3'd0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 1), "trap_hold");
        do_reset();
`else
        run(32'h0000007F, 0, 0, 1'b0);
        run(32'h00500093, 0, 0, 1'b0);
`endif
        step(1'b1, 32'h0020A023, 1'b0, 1'b0, pk(cur_fmt, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0), "fetch_sw");
        step(1'b0, rw(), 1'b0, 1'b0, pk(cur_fmt, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0), "decode_sw");
        step(1'b0, rw(), 1'b0, 1'b0, pk(3'd2, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 1, 0, 0), "exec_sw");
        for (int i = 0; i < 2; i++)
            step(1'b0, rw(), 1'b0, 1'b0, pk(3'd2, 0, 1, 1, 0, 2'd0, 0, 2'd0, 0, 1, 0, 0), "mem_sw_wait");
        do_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_WAIT_MAX, default 15, the maximum number of cycles a memory request waits for ready before a bus error.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  fetch data valid.
- imem_rdata  in  32  fetched instruction.
- ir  out  32  latched instruction register, drives the immediate generator.
- imm_fmt  out  3  immediate format: 0 none, 1 I, 2 S, 3 B, 4 J, 5 U.
- alu_src_imm  out  1  ALU operand B is the immediate.
- branch_taken  in  1  comparator result, sampled in EXEC.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write.
- dmem_ready  in  1  data access complete.
- reg_we  out  1  register file write enable.
- wb_sel  out  2  write-back source: 0 ALU, 1 MEM, 2 PC+4.
- pc_we  out  1  PC update enable.
- pc_sel  out  2  next PC: 0 PC+4, 1 branch target, 2 JAL target, 3 JALR target.
- retire  out  1  one-cycle pulse per completed instruction.
- bus_err  out  1  sticky memory timeout flag.
- illegal  out  1  sticky illegal-opcode flag (see Configuration).

Function
REQ-003 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB and ERR, plus TRAP when the macro is enabled; outputs are decoded from state and ir, and are 0 where not stated.
REQ-004 FETCH: imem_req=1; when imem_ready=1, ir<=imem_rdata and the next state is DECODE; ir is held in every other state.
REQ-005 DECODE: one cycle; imm_fmt is registered from ir[6:0] as follows: 0010011/0000011/1100111 ->I, 0100011 ->S, 1100011 ->B, 1101111 ->J, 0110111/0010111 ->U, others ->0; next state is EXEC.
REQ-006 imm_fmt SHALL hold from DECODE until the next DECODE; alu_src_imm=1 in EXEC/MEM/WB whenever imm_fmt is nonzero and the opcode is not branch.
REQ-007 EXEC, load/store: next state is MEM.
REQ-008 EXEC, branch: pc_we=1, pc_sel=branch_taken?1:0 (Mealy on branch_taken), retire=1; next state is FETCH.
REQ-009 EXEC, R, I-ALU, LUI, AUIPC, JAL or JALR: next state is WB.
REQ-010 MEM: dmem_req=1 and dmem_we=1 for a store; when dmem_ready=1, a store gives pc_we=1, pc_sel=0, retire=1 and goes to FETCH; a load goes to WB.
REQ-011 WB: reg_we=1, pc_we=1, retire=1; wb_sel is 1 for a load, 2 for JAL/JALR, 0 otherwise; pc_sel is 2 for JAL, 3 for JALR, 0 otherwise; next state is FETCH.
REQ-012 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle ready is low; if it reaches MEM_WAIT_MAX with ready still low, the next state is ERR.
REQ-013 Ready asserted in the same cycle the counter hits MEM_WAIT_MAX SHALL win, so no error is raised.
REQ-014 ERR: bus_err=1 and all requests and enables are 0; ERR is left only by reset.
REQ-015 Minimum latency SHALL be: branch 3 cycles, store 4, ALU/jump 4, load 5, each with zero-wait memory.
REQ-016 imem_req/dmem_req SHALL stay high until ready, with no drop mid-wait.

Reset
REQ-017 With rst=1 at a clock edge: state<=FETCH, ir<=32'h00000013 (NOP), imm_fmt<=0, counter<=0, bus_err<=0, illegal<=0.
REQ-018 Reset SHALL take priority over every transition, including mid-wait in MEM, where the in-flight request drops the cycle after.

Configuration
REQ-019 The macro is MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
REQ-020 When defined, an unrecognised opcode in EXEC goes to TRAP, which sets illegal=1, keeps all enables at 0, and is left only by reset.
REQ-021 When undefined, an unrecognised opcode in EXEC is executed as a NOP: pc_we=1, pc_sel=0, retire=1, next state FETCH; illegal is tied to 0.

Verification
REQ-022 The bench SHALL cover these scenarios:
- addi 0x00500093, zero-wait -> FETCH,DECODE,EXEC,WB; imm_fmt=1; reg_we=1 and wb_sel=0 in cycle 4; retire once.
- lw 0x0000A103 with dmem_ready delayed 3 cycles -> dmem_req high for 4 cycles; then WB with wb_sel=1; 8 cycles total.
- beq 0x00000463 with branch_taken=1 -> imm_fmt=3; pc_we=1 and pc_sel=1 in EXEC; retire in cycle 3.
- imem_ready held 0 -> ERR after MEM_WAIT_MAX=15 waits; bus_err=1 and stays 1 until rst; ready on wait 15 -> no error.
- opcode 0x0000007F -> macro on: illegal=1 and stall; macro off: pc_sel=0 retire, continue.
- rst asserted during MEM wait of sw -> next cycle state FETCH, dmem_req=0, ir=0x00000013.
